// File: rtl/avalon_bus_arbiter.sv
// Purpose : shares one Avalon-MM master port between instruction fetch and data access.
//           Optional build macro: ARB_FAIR_EN (alternating winner on simultaneous requests).
// Latency : command on the bus 1 cycle after the request, valid 1 cycle after the last
//           avm_waitrequest-low cycle. Stalls are combinational. Waitrequest holds every avm_* output.
module avalon_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  // instruction fetch requester
  input  logic                f_read,
  input  logic [ADDR_W-1:0]   f_address,
  output logic [DATA_W-1:0]   f_readdata,
  output logic                f_valid,
  output logic                f_stall,
  // memory-stage data requester
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W-1:0]   d_writedata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_valid,
  output logic                d_stall,
  // Avalon-MM master
  output logic                avm_read,
  output logic                avm_write,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t              state_q;
  logic                avm_read_q;
  logic                avm_write_q;
  logic [ADDR_W-1:0]   avm_address_q;
  logic [DATA_W-1:0]   avm_writedata_q;
  logic [BE_W-1:0]     avm_byteenable_q;
  logic [DATA_W-1:0]   f_readdata_q;
  logic [DATA_W-1:0]   d_readdata_q;
  logic                f_valid_q;
  logic                d_valid_q;

  // A requester completing this cycle still holds its level; mask it so it is not re-issued.
  logic f_req;
  logic d_req;
  logic grant_d;
  logic grant_f;

  assign f_req = f_read & ~f_valid_q;
  assign d_req = (d_read | d_write) & ~d_valid_q;

`ifdef ARB_FAIR_EN
  // 1 = data was granted most recently, 0 = fetch
  logic last_grant_q;
  assign grant_d = d_req & (~f_req | ~last_grant_q);
`else
  assign grant_d = d_req;
`endif
  assign grant_f = f_req & ~grant_d;

  // Bus FSM: grant in IDLE, hold while waitrequest, complete and pulse valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      avm_read_q       <= 1'b0;
      avm_write_q      <= 1'b0;
      avm_address_q    <= '0;
      avm_writedata_q  <= '0;
      avm_byteenable_q <= '0;
      f_readdata_q     <= '0;
      d_readdata_q     <= '0;
      f_valid_q        <= 1'b0;
      d_valid_q        <= 1'b0;
`ifdef ARB_FAIR_EN
      last_grant_q     <= 1'b0;
`endif
    end else begin
      f_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            // read+write together is a write
            state_q          <= BUSY_D;
            avm_write_q      <= d_write;
            avm_read_q       <= ~d_write;
            avm_address_q    <= d_address & WORD_MASK;
            avm_writedata_q  <= d_writedata;
            avm_byteenable_q <= d_byteenable;
`ifdef ARB_FAIR_EN
            last_grant_q     <= 1'b1;
`endif
          end else if (grant_f) begin
            state_q          <= BUSY_F;
            avm_read_q       <= 1'b1;
            avm_write_q      <= 1'b0;
            avm_address_q    <= f_address & WORD_MASK;
            avm_writedata_q  <= '0;
            avm_byteenable_q <= '1;
`ifdef ARB_FAIR_EN
            last_grant_q     <= 1'b0;
`endif
          end
        end
        BUSY_F: begin
          if (!avm_waitrequest) begin
            state_q      <= IDLE;
            avm_read_q   <= 1'b0;
            f_readdata_q <= avm_readdata;
            f_valid_q    <= 1'b1;
          end
        end
        BUSY_D: begin
          if (!avm_waitrequest) begin
            state_q     <= IDLE;
            avm_read_q  <= 1'b0;
            avm_write_q <= 1'b0;
            if (avm_read_q) begin
              d_readdata_q <= avm_readdata;
            end
            d_valid_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign avm_read       = avm_read_q;
  assign avm_write      = avm_write_q;
  assign avm_address    = avm_address_q;
  assign avm_writedata  = avm_writedata_q;
  assign avm_byteenable = avm_byteenable_q;
  assign f_readdata     = f_readdata_q;
  assign d_readdata     = d_readdata_q;
  assign f_valid        = f_valid_q;
  assign d_valid        = d_valid_q;
  assign f_stall        = f_read & ~f_valid_q;
  assign d_stall        = (d_read | d_write) & ~d_valid_q;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: transaction-level model checked every cycle,
// plus literal expectations at hand-computed cycles of each directed scenario.
// Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
module tb_avalon_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        f_read;
  logic [31:0] f_address;
  logic [31:0] f_readdata;
  logic        f_valid;
  logic        f_stall;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_readdata;
  logic        d_valid;
  logic        d_stall;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_address;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .f_read(f_read), .f_address(f_address), .f_readdata(f_readdata),
    .f_valid(f_valid), .f_stall(f_stall),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_readdata(d_readdata), .d_valid(d_valid), .d_stall(d_stall),
    .avm_read(avm_read), .avm_write(avm_write), .avm_address(avm_address),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  bit run_cmp    = 1'b1;
  bit auto_drop  = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // owner of the bus: 0 none, 1 fetch, 2 data
  int          m_owner = 0;
  bit          m_rd = 0, m_wr = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic [3:0]  m_be = 0;
  logic [31:0] m_frd = 0, m_drd = 0;
  bit          m_fv = 0, m_dv = 0;
  bit          m_last_data = 0;

  always @(posedge clk) begin
    bit fv_now, dv_now, want_f, want_d, pick_d;
    fv_now = m_fv;
    dv_now = m_dv;
    m_fv = 0;
    m_dv = 0;
    if (reset) begin
      m_owner = 0; m_rd = 0; m_wr = 0; m_addr = 0; m_wdata = 0; m_be = 0;
      m_frd = 0; m_drd = 0; m_last_data = 0;
    end else if (m_owner != 0) begin
      if (!avm_waitrequest) begin
        if (m_owner == 1) begin
          m_frd = avm_readdata; m_fv = 1;
        end else begin
          if (m_rd) m_drd = avm_readdata;
          m_dv = 1;
        end
        m_owner = 0; m_rd = 0; m_wr = 0;
      end
    end else begin
      want_f = f_read && !fv_now;
      want_d = (d_read || d_write) && !dv_now;
`ifdef ARB_FAIR_EN
      pick_d = want_d && (!want_f || !m_last_data);
`else
      pick_d = want_d;
`endif
      if (pick_d) begin
        m_owner = 2; m_wr = d_write; m_rd = !d_write;
        m_addr = d_address & 32'hFFFF_FFFC; m_wdata = d_writedata; m_be = d_byteenable;
        m_last_data = 1;
      end else if (want_f) begin
        m_owner = 1; m_rd = 1; m_wr = 0;
        m_addr = f_address & 32'hFFFF_FFFC; m_be = 4'hF;
        m_last_data = 0;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("avm_read",   32'(avm_read),   32'(m_rd));
      chk("avm_write",  32'(avm_write),  32'(m_wr));
      chk("f_valid",    32'(f_valid),    32'(m_fv));
      chk("d_valid",    32'(d_valid),    32'(m_dv));
      chk("f_stall",    32'(f_stall),    32'(f_read && !m_fv));
      chk("d_stall",    32'(d_stall),    32'((d_read || d_write) && !m_dv));
      chk("f_readdata", f_readdata, m_frd);
      chk("d_readdata", d_readdata, m_drd);
      chk("valid_excl", 32'(f_valid & d_valid), 32'd0);
      if (m_rd || m_wr) begin
        chk("avm_address",    avm_address, m_addr);
        chk("avm_byteenable", 32'(avm_byteenable), 32'(m_be));
      end
      if (m_wr) chk("avm_writedata", avm_writedata, m_wdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    if (auto_drop) begin
      if (f_valid) f_read = 1'b0;
      if (d_valid) begin d_read = 1'b0; d_write = 1'b0; end
    end
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic pair(output bit d_first, output bit done);
    bit seen;
    seen = 0;
    d_first = 0;
    tick();
    f_read = 1; f_address = 32'h0000_0100;
    d_read = 1; d_write = 0; d_address = 32'h0000_0204; d_byteenable = 4'hF;
    for (int i = 0; i < 20 && (f_read || d_read); i++) begin
      tick();
      if (!seen && (f_valid || d_valid)) begin
        seen = 1;
        d_first = d_valid;
      end
    end
    done = !(f_read || d_read);
  endtask

  initial begin
    bit d_first, done;
    reset = 1; f_read = 0; f_address = 0; d_read = 0; d_write = 0;
    d_address = 0; d_writedata = 0; d_byteenable = 0;
    avm_waitrequest = 0; avm_readdata = 0;
    tick(); tick();
    reset = 0;
    neg();
    chk("rst_avm_read", 32'(avm_read), 32'd0);
    chk("rst_avm_addr", avm_address, 32'd0);
    chk("rst_f_valid",  32'(f_valid), 32'd0);

    // Fetch only, zero wait states
    tick(); f_read = 1; f_address = 32'h0000_1003; avm_readdata = 32'hDEAD_BEEF;
    tick(); neg();
    chk("t1_c1_avm_read", 32'(avm_read), 32'd1);
    chk("t1_c1_addr", avm_address, 32'h0000_1000);
    chk("t1_c1_be", 32'(avm_byteenable), 32'hF);
    tick(); neg();
    chk("t1_c2_f_valid", 32'(f_valid), 32'd1);
    chk("t1_c2_rdata", f_readdata, 32'hDEAD_BEEF);
    chk("t1_c2_avm_read", 32'(avm_read), 32'd0);

    // Data write with 3 wait states and a concurrent fetch
    tick();
    d_write = 1; d_address = 32'h0000_2002; d_writedata = 32'h1234_5678; d_byteenable = 4'b0011;
    f_read = 1; f_address = 32'h0000_3000; avm_readdata = 32'hCAFE_F00D;
    tick(); avm_waitrequest = 1; neg();
    chk("t2_c1_avm_write", 32'(avm_write), 32'd1);
    chk("t2_c1_addr", avm_address, 32'h0000_2000);
    chk("t2_c1_be", 32'(avm_byteenable), 32'h3);
    chk("t2_c1_f_stall", 32'(f_stall), 32'd1);
    tick(); tick();
    tick(); avm_waitrequest = 0; neg();
    chk("t2_c4_avm_write", 32'(avm_write), 32'd1);
    chk("t2_c4_wdata", avm_writedata, 32'h1234_5678);
    tick(); neg();
    chk("t2_c5_d_valid", 32'(d_valid), 32'd1);
    chk("t2_c5_avm_write", 32'(avm_write), 32'd0);
    chk("t2_c5_f_stall", 32'(f_stall), 32'd1);
    tick(); neg();
    chk("t2_c6_avm_read", 32'(avm_read), 32'd1);
    chk("t2_c6_addr", avm_address, 32'h0000_3000);
    chk("t2_c6_d_valid", 32'(d_valid), 32'd0);
    tick(); neg();
    chk("t2_c7_f_rdata", f_readdata, 32'hCAFE_F00D);
    tick();

    // Simultaneous requests: last grant was fetch, so data wins in either build
    avm_readdata = 32'h0BAD_F00D;
    pair(d_first, done);
    chk("pair1_done", 32'(done), 32'd1);
    chk("pair1_data_first", 32'(d_first), 32'd1);
    // A solo data access makes data the last grant before the second pair
    tick(); d_read = 1; d_address = 32'h0000_0300; d_byteenable = 4'hF;
    for (int i = 0; i < 10 && d_read; i++) tick();
    pair(d_first, done);
    chk("pair2_done", 32'(done), 32'd1);
`ifdef ARB_FAIR_EN
    chk("pair2_data_first", 32'(d_first), 32'd0);
`else
    chk("pair2_data_first", 32'(d_first), 32'd1);
`endif
    tick();

    // Held fetch request through completion plus one cycle
    auto_drop = 0;
    tick(); f_read = 1; f_address = 32'h0000_0040; avm_readdata = 32'h1111_2222;
    tick();
    tick(); neg();
    chk("t4_c2_f_valid", 32'(f_valid), 32'd1);
    tick(); neg();
    chk("t4_c3_no_dup", 32'(avm_read), 32'd0);
    tick(); f_read = 0; neg();
    chk("t4_c4_reissue", 32'(avm_read), 32'd1);
    tick(); neg();
    chk("t4_c5_f_valid", 32'(f_valid), 32'd1);
    auto_drop = 1;
    tick();

    // Reset in the middle of a stalled data read
    tick(); d_read = 1; d_write = 0; d_address = 32'h0000_0080;
    tick(); avm_waitrequest = 1; neg();
    chk("t5_c1_avm_read", 32'(avm_read), 32'd1);
    tick(); reset = 1; d_read = 0;
    tick(); reset = 0; avm_waitrequest = 0; neg();
    chk("t5_c3_avm_read", 32'(avm_read), 32'd0);
    chk("t5_c3_d_valid", 32'(d_valid), 32'd0);
    tick(); neg();
    chk("t5_c4_d_valid", 32'(d_valid), 32'd0);
    chk("t5_c4_f_valid", 32'(f_valid), 32'd0);
    tick(); f_read = 1; f_address = 32'h0000_0090; avm_readdata = 32'h5A5A_A5A5;
    tick(); neg();
    chk("t5_c6_avm_read", 32'(avm_read), 32'd1);
    chk("t5_c6_addr", avm_address, 32'h0000_0090);
    tick(); neg();
    chk("t5_c7_f_valid", 32'(f_valid), 32'd1);
    chk("t5_c7_rdata", f_readdata, 32'h5A5A_A5A5);
    tick(); tick();

    run_cmp = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
